// File: rtl/mem_read_d_agen.sv
// Read-address generator for the D operand memory of the systolic GEMM datapath.
// Streams one address per accepted beat, with a one-hot row activate aligned to each address.
module mem_read_d_agen #(
    parameter int unsigned N1           = 4,
    parameter int unsigned N2           = 4,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [MATRIXSIZE_W-1:0] M3,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic [MATRIXSIZE_W-1:0] row_stride,
    input  logic [MATRIXSIZE_W-1:0] phase_stride,
    input  logic                    rd_ready,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_valid,
    output logic [N1-1:0]           activate,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam int unsigned ROW_W   = (N1 > 1) ? $clog2(N1) : 1;
    localparam int unsigned LOG2_N2 = $clog2(N2);
    localparam logic [MATRIXSIZE_W-1:0] MINI_MASK = MATRIXSIZE_W'(N2 - 1);
    localparam logic [ROW_W-1:0]        ROW_LAST  = ROW_W'(N1 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Job configuration captured at start
    logic                    mode_q, mode_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [MATRIXSIZE_W-1:0] m3_q, m3_d;
    logic [MATRIXSIZE_W-1:0] phases_q, phases_d;
    logic [ADDR_W-1:0]       row_stride_q, row_stride_d;
    logic [ADDR_W-1:0]       phase_stride_q, phase_stride_d;

    // Loop counters and running offset accumulators
    logic [MATRIXSIZE_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [MATRIXSIZE_W-1:0] phase_q, phase_d;
    logic [ADDR_W-1:0]       row_acc_q, row_acc_d;
    logic [ADDR_W-1:0]       phase_acc_q, phase_acc_d;

    logic [ADDR_W-1:0]       rd_addr_d;
    logic                    rd_valid_d;
    logic [N1-1:0]           activate_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    cfg_err_d;

    logic                    cfg_bad_c;
    logic                    col_last_c;
    logic                    row_last_c;
    logic                    phase_last_c;

    // Reversed order flips the mini-column index inside each N2 group
    function automatic logic [ADDR_W-1:0] col_term(input logic [MATRIXSIZE_W-1:0] col,
                                                   input logic                    lin);
        logic [MATRIXSIZE_W-1:0] c;
        c = lin ? col : (col ^ MINI_MASK);
        return ADDR_W'(c);
    endfunction

    assign cfg_bad_c    = (M3 == '0) || (M1dN1 == '0) ||
                          (!mode && (M3[LOG2_N2-1:0] != '0));
    assign col_last_c   = (col_q == (m3_q - MATRIXSIZE_W'(1)));
    assign row_last_c   = (row_q == ROW_LAST);
    assign phase_last_c = (phase_q == (phases_q - MATRIXSIZE_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mode_q         <= 1'b0;
            base_q         <= '0;
            m3_q           <= '0;
            phases_q       <= '0;
            row_stride_q   <= '0;
            phase_stride_q <= '0;
            col_q          <= '0;
            row_q          <= '0;
            phase_q        <= '0;
            row_acc_q      <= '0;
            phase_acc_q    <= '0;
            rd_addr        <= '0;
            rd_valid       <= 1'b0;
            activate       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            base_q         <= base_d;
            m3_q           <= m3_d;
            phases_q       <= phases_d;
            row_stride_q   <= row_stride_d;
            phase_stride_q <= phase_stride_d;
            col_q          <= col_d;
            row_q          <= row_d;
            phase_q        <= phase_d;
            row_acc_q      <= row_acc_d;
            phase_acc_q    <= phase_acc_d;
            rd_addr        <= rd_addr_d;
            rd_valid       <= rd_valid_d;
            activate       <= activate_d;
            busy           <= busy_d;
            done           <= done_d;
            cfg_err        <= cfg_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        base_d         = base_q;
        m3_d           = m3_q;
        phases_d       = phases_q;
        row_stride_d   = row_stride_q;
        phase_stride_d = phase_stride_q;
        col_d          = col_q;
        row_d          = row_q;
        phase_d        = phase_q;
        row_acc_d      = row_acc_q;
        phase_acc_d    = phase_acc_q;
        rd_addr_d      = rd_addr;
        rd_valid_d     = rd_valid;
        activate_d     = activate;
        busy_d         = busy;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad_c) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d        = RUN;
                        mode_d         = mode;
                        base_d         = base_addr;
                        m3_d           = M3;
                        phases_d       = M1dN1;
                        row_stride_d   = ADDR_W'(row_stride);
                        phase_stride_d = ADDR_W'(phase_stride);
                        col_d          = '0;
                        row_d          = '0;
                        phase_d        = '0;
                        row_acc_d      = '0;
                        phase_acc_d    = '0;
                        rd_addr_d      = base_addr + col_term('0, mode);
                        rd_valid_d     = 1'b1;
                        activate_d     = N1'(1);
                        busy_d         = 1'b1;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    col_d      = '0;
                    row_d      = '0;
                    phase_d    = '0;
                    row_acc_d  = '0;
                    phase_acc_d = '0;
                    rd_addr_d  = '0;
                    rd_valid_d = 1'b0;
                    activate_d = '0;
                    busy_d     = 1'b0;
                end else if (rd_ready) begin
                    if (col_last_c && row_last_c && phase_last_c) begin
                        state_d     = FIN;
                        col_d       = '0;
                        row_d       = '0;
                        phase_d     = '0;
                        row_acc_d   = '0;
                        phase_acc_d = '0;
                        rd_valid_d  = 1'b0;
                        activate_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        // Innermost column first, then row, then phase
                        if (col_last_c) begin
                            col_d = '0;
                            if (row_last_c) begin
                                row_d       = '0;
                                row_acc_d   = '0;
                                phase_d     = phase_q + MATRIXSIZE_W'(1);
                                phase_acc_d = phase_acc_q + phase_stride_q;
                            end else begin
                                row_d     = row_q + ROW_W'(1);
                                row_acc_d = row_acc_q + row_stride_q;
                            end
                        end else begin
                            col_d = col_q + MATRIXSIZE_W'(1);
                        end
                        rd_addr_d  = base_q + phase_acc_d + row_acc_d + col_term(col_d, mode_q);
                        activate_d = N1'(1) << row_d;
                    end
                end
            end

            FIN: begin
                state_d    = IDLE;
                rd_addr_d  = '0;
                rd_valid_d = 1'b0;
                activate_d = '0;
                busy_d     = 1'b0;
            end

            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
                activate_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_read_d_agen.md
# mem_read_d_agen

Parametrised read-address generator for the D operand memory of the systolic GEMM datapath. It is the successor to the fixed D-read sequencer. The block streams one address per accepted beat with an aligned one-hot row activate. It adds a start/busy/done handshake, downstream back-pressure, abort, a base address, runtime row and phase strides, and a selectable column order (N2-group reversed or linear). It sits between the GEMM controller, which issues start, and the D memory bank read ports plus the systolic row-load enables.

## Interface
Parameters:
- N1, 4: systolic rows; width of activate.
- N2, 4: mini-column group size; power of two, ≥2.
- MATRIXSIZE_W, 16: width of matrix dimension and stride inputs.
- ADDR_W, 12: read address width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- abort  in  1  synchronous cancel of the running job.
- mode  in  1  0 = N2-group reversed column order, 1 = linear column order.
- base_addr  in  ADDR_W  job base address.
- M3  in  MATRIXSIZE_W  columns per row pass.
- M1dN1  in  MATRIXSIZE_W  number of phases.
- row_stride  in  MATRIXSIZE_W  address step per systolic row.
- phase_stride  in  MATRIXSIZE_W  address step per phase.
- rd_ready  in  1  downstream accepts the current beat.
- rd_addr  out  ADDR_W  read address.
- rd_valid  out  1  rd_addr/activate valid.
- activate  out  N1  one-hot row select, aligned with rd_addr.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at normal job completion.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation
- The FSM has three states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches all configuration inputs; later input changes are ignored until the next job.
  - The start is rejected if M3==0, M1dN1==0, or (mode==0 and M3[log2(N2)-1:0]!=0).
  - On rejection: cfg_err pulses, the FSM stays in IDLE, and nothing is emitted.
  - Otherwise the FSM goes to RUN.
- Loop nest, outer to inner:
  - phase 0..M1dN1-1.
  - sys_row 0..N1-1.
  - col 0..M3-1, split as grp = col/N2 and mini = col mod N2.
- Column term:
  - mode 0: grp*N2 + (N2-1-mini).
  - mode 1: col.
- rd_addr = base_addr + phase*phase_stride + sys_row*row_stride + column term.
  - Computed at full precision, then truncated to ADDR_W (modulo wrap; no error).
  - phase*phase_stride and sys_row*row_stride are maintained as running accumulators, not multipliers.
- activate = (1 << sys_row) while rd_valid=1, else all zeros.
- Beat accounting:
  - A beat completes when rd_valid && rd_ready.
  - The counters advance only on completion.
  - Total beats per job = M1dN1*N1*M3.
- After the final completed beat the FSM moves to FIN: rd_valid=0, done=1 for one cycle, then IDLE.
- abort in RUN or FIN: next state is IDLE, outputs are cleared, done is not pulsed. abort in IDLE has no effect.
- start while busy=1 is ignored; no error is raised.
- Legacy equivalence: mode=0, base_addr=0, row_stride=0, phase_stride=M3 reproduces the old D-read sequence. Unlike the old block, activate is aligned with its address.

## Timing
- Reset values: rd_addr=0, rd_valid=0, activate=0, busy=0, done=0, cfg_err=0, FSM=IDLE, all counters 0. Reset is asynchronous and may be asserted mid-job; the job is discarded.
- All outputs are registered.
- An accepted start at edge k gives busy=1 and rd_valid=1 with the first beat after edge k.
- cfg_err is high for the cycle after the rejecting edge.
- In RUN, rd_valid stays 1 continuously. With rd_ready held at 1, there is one new address per cycle and no bubbles across col, row or phase wraps.
- Stall: when rd_valid=1 and rd_ready=0, rd_addr and activate hold bit-stable.
- When the last beat completes at edge j: after edge j, rd_valid=0, busy=1, done=1. After edge j+1, busy=0 and done=0, and a new start may be sampled at edge j+1's following cycle.
- abort has priority over rd_ready on the same edge; that beat is not counted.
- Start-to-done latency with no stalls = M1dN1*N1*M3 + 1 cycles.

## Test plan
- Legacy sequence:
  - Stimulus: N1=4, N2=4, M3=8, M1dN1=2, mode 0, base 0, row_stride 0, phase_stride 8, rd_ready=1.
  - Phase 0, each row: addresses 3,2,1,0,7,6,5,4, with activate 0001, 0010, 0100, 1000 per row.
  - Phase 1: 11,10,9,8,15,14,13,12.
  - 64 beats, done at cycle 65, busy drops the next cycle.
- Linear mode with strides:
  - Stimulus: mode 1, base 100, M3=3, M1dN1=2, N1=2, row_stride 10, phase_stride 50.
  - Required addresses: 100,101,102,110,111,112,150,151,152,160,161,162.
- Back-pressure:
  - Stimulus: random rd_ready at 50% density on the legacy config.
  - Required: address/activate stable while stalled, sequence identical to the no-stall run, done only after beat 64 is accepted.
- Config errors and start while busy:
  - Stimulus: start with M3=0, then M3=6 in mode 0 (N2=4).
  - Required: cfg_err pulse each time, busy stays 0.
  - Stimulus: start pulsed mid-job.
  - Required: ignored, no cfg_err.
- Wrap and abort:
  - Stimulus: ADDR_W=8, base 250, mode 1, M3=8.
  - Required: addresses 250..255, 0, 1.
  - Stimulus: abort at beat 5.
  - Required: rd_valid=0 and busy=0 next cycle, no done; the next job starts cleanly from beat 0.
- Reset mid-job:
  - Stimulus: rst_n low asynchronously between edges during RUN.
  - Required: all outputs 0 immediately.
  - Stimulus: release, then start.
  - Required: the full sequence restarts from the first address.
